// File: rtl/wb_stream_reader_fifo.sv
// Stream-to-Wishbone read FIFO: 2^AW x DW buffer with registered read data and burst threshold.
// Optional sticky read-underflow flag enabled by defining WB_STREAM_READER_FIFO_ERR_EN.
module wb_stream_reader_fifo #(
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 4,
  parameter int unsigned BURST_LEN = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   stream_s_data_i,
  input  logic            stream_s_valid_i,
  output logic            stream_s_ready_o,
  input  logic            fifo_rd_en_i,
  output logic [DW-1:0]   fifo_rd_data_o,
  output logic            fifo_empty_o,
  input  logic            flush_i,
  output logic [AW:0]     cnt,
  output logic            burst_rdy_o,
  output logic            err_o
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          full_c, empty_c, wr_en_c, pop_c;

  // Status flags come from the registered count only.
  assign full_c           = (cnt_q == CW'(DEPTH));
  assign empty_c          = (cnt_q == '0);
  assign stream_s_ready_o = !full_c && !rst;
  assign fifo_empty_o     = empty_c;
  assign burst_rdy_o      = (cnt_q >= CW'(BURST_LEN));
  assign cnt              = cnt_q;
  assign fifo_rd_data_o   = rd_data_q;

  assign wr_en_c = stream_s_valid_i && stream_s_ready_o && !flush_i;
  assign pop_c   = fifo_rd_en_i && !empty_c && !flush_i && !rst;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;
    if (wr_en_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_c) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end
    case ({wr_en_c, pop_c})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    // Flush discards contents but leaves the last popped word visible.
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage array carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wr_ptr_q] <= stream_s_data_i;
    end
  end

`ifdef WB_STREAM_READER_FIFO_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (fifo_rd_en_i && empty_c) begin
      err_d = 1'b1;
    end
    if (flush_i) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: doc/wb_stream_reader_fifo.md
WB_STREAM_READER_FIFO -- requirements
Module: wb_stream_reader_fifo

Interface
REQ-001 The block SHALL have parameter DW, default 32, data word width in bits.
REQ-002 The block SHALL have parameter AW, default 4, log2 of FIFO depth (depth = 2^AW words).
REQ-003 The block SHALL have parameter BURST_LEN, default 8, the fill threshold for burst_rdy_o, legal range 1..2^AW.
REQ-004 The block SHALL have port clk, input, 1, the single clock for all logic.
REQ-005 The block SHALL have port rst, input, 1, with reset synchronous to clk and active-high.
REQ-006 The block SHALL have port stream_s_data_i, input, DW, the incoming stream data.
REQ-007 The block SHALL have port stream_s_valid_i, input, 1, the incoming stream valid.
REQ-008 The block SHALL have port stream_s_ready_o, output, 1, asserted when the FIFO accepts a word this cycle.
REQ-009 The block SHALL have port fifo_rd_en_i, input, 1, the Wishbone-side pop request.
REQ-010 The block SHALL have port fifo_rd_data_o, output, DW, the popped word, registered.
REQ-011 The block SHALL have port fifo_empty_o, output, 1, asserted when the FIFO holds zero words.
REQ-012 The block SHALL have port flush_i, input, 1, a synchronous discard of all stored words.
REQ-013 The block SHALL have port cnt, output, AW+1, the number of stored words.
REQ-014 The block SHALL have port burst_rdy_o, output, 1, asserted when cnt >= BURST_LEN.
REQ-015 The block SHALL have port err_o, output, 1, a sticky read-underflow flag (see Configuration).

Function
REQ-016 The block SHALL implement storage as 2^AW x DW memory with AW-bit read and write pointers that wrap from 2^AW-1 to 0.
REQ-017 stream_s_ready_o SHALL be !full & !rst, where full means cnt == 2^AW; a write SHALL occur on the clk edge where stream_s_valid_i & stream_s_ready_o.
REQ-018 A pop SHALL occur when fifo_rd_en_i & !fifo_empty_o; fifo_rd_data_o SHALL present the popped word on the cycle after the pop edge (1-cycle latency) and SHALL hold its value when no pop occurs.
REQ-019 fifo_rd_en_i while empty SHALL be ignored: pointers, cnt and fifo_rd_data_o SHALL remain unchanged.
REQ-020 cnt SHALL increment on write-only cycles, decrement on pop-only cycles, and stay unchanged when both or neither occur.
REQ-021 Simultaneous write and pop at any 0 < cnt < 2^AW SHALL both complete, leaving cnt unchanged and preserving order.
REQ-022 When full, a pop SHALL proceed and stream_s_ready_o SHALL reassert the next cycle; when empty, a write SHALL deassert fifo_empty_o the next cycle, with no same-cycle bypass.
REQ-023 fifo_empty_o and burst_rdy_o SHALL be decoded from registered cnt only.
REQ-024 flush_i SHALL zero both pointers and cnt at the next edge, overriding any concurrent write or pop; fifo_rd_data_o SHALL hold.
REQ-025 Words SHALL be popped in exact write order with no loss or duplication across pointer wrap.

Reset
REQ-026 While rst is high, the block SHALL zero cnt, both pointers, fifo_rd_data_o and err_o at each edge, with stream_s_ready_o=0, fifo_empty_o=1 and burst_rdy_o=0.
REQ-027 rst SHALL override flush_i, writes and pops; an assertion mid-burst SHALL discard all contents.
REQ-028 Memory contents SHALL NOT require reset.

Configuration
REQ-029 With macro WB_STREAM_READER_FIFO_ERR_EN defined, err_o SHALL set on any edge where fifo_rd_en_i & fifo_empty_o, and SHALL clear only by rst or flush_i.
REQ-030 Without WB_STREAM_READER_FIFO_ERR_EN, err_o SHALL be constant 0 and no error logic SHALL be synthesized.

Verification
REQ-031 The bench SHALL cover: AW=4, reset, then write 0x00..0x0F with no pops -> cnt=16, stream_s_ready_o=0, burst_rdy_o=1 from cnt=8.
REQ-032 The bench SHALL cover: from full, pop 16 words -> fifo_rd_data_o=0x00..0x0F, each one cycle after its pop, then fifo_empty_o=1 and cnt=0.
REQ-033 The bench SHALL cover: continuous write and pop for 40 words starting at cnt=3 -> cnt holds 3, output order is exact, and pointers wrap twice.
REQ-034 The bench SHALL cover: ERR_EN defined, pop while empty -> err_o=1 with cnt=0 and fifo_rd_data_o unchanged; flush_i -> err_o=0. Without ERR_EN, err_o stays 0.
REQ-035 The bench SHALL cover: cnt=10 with flush_i and stream_s_valid_i high together -> cnt=0 and fifo_empty_o=1 next cycle, and the concurrent word is dropped.
REQ-036 The bench SHALL cover: rst asserted at cnt=7 during writes -> cnt=0, stream_s_ready_o=0 while rst is high, and ready=1 on the first cycle after release.
